// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing constants and the visible/sync window decode
// shared by the VGA timing generator.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE  = 640;
  localparam int H_FRONT    = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BACK     = 48;
  localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE  = 480;
  localparam int V_FRONT    = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BACK     = 33;
  localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int SYNC_DELAY = 2;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

  function automatic logic is_visible(input coord_t x, input coord_t y,
                                      input coord_t x_lim, input coord_t y_lim);
    return (x < x_lim) && (y < y_lim);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Shift register that realigns the sync pair with the downstream mapper pipeline;
// resets to all ones so the active-low syncs stay deasserted.
module sync_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = vga_clk ^ reset;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '1;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel/line counters with registered blank, sync and
// strobe decode, plus a frame counter for animation logic.
module vga_timing_gen #(
  parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BACK     = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BACK     = vga_timing_pkg::V_BACK,
  parameter int SYNC_DELAY = vga_timing_pkg::SYNC_DELAY
) (
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  import vga_timing_pkg::*;

  localparam coord_t H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS    = 10'(H_VISIBLE);
  localparam coord_t V_VIS    = 10'(V_VISIBLE);
  localparam coord_t HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t     x_next;
  coord_t     y_next;
  logic       hs_raw;
  logic       vs_raw;
  logic [1:0] sync_out;
  logic       at_origin;

  // Every output is decoded from the next count so it lands in the same cycle as it.
  always_comb begin
    x_next = DrawX + 10'd1;
    y_next = DrawY;
    if (DrawX == H_LAST) begin
      x_next = '0;
      y_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
    end
  end

  assign at_origin = (x_next == '0) && (y_next == '0);

  // Reset parks the counters on the last pixel so the first edge enters (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      blank       <= 1'b0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= x_next;
      DrawY       <= y_next;
      blank       <= is_visible(x_next, y_next, H_VIS, V_VIS);
      hs_raw      <= ~in_window(x_next, HS_FIRST, HS_LAST);
      vs_raw      <= ~in_window(y_next, VS_FIRST, VS_LAST);
      line_start  <= (x_next == '0);
      frame_start <= at_origin;
      if (at_origin) frame_count <= frame_count + 16'd1;
    end
  end

  sync_delay_line #(
    .WIDTH(2),
    .DEPTH(SYNC_DELAY)
  ) u_sync_delay (
    .vga_clk(vga_clk),
    .reset  (reset),
    .din    ({hs_raw, vs_raw}),
    .dout   (sync_out)
  );

  assign hs = sync_out[1];
  assign vs = sync_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default build, a no-delay build and a
// reduced-geometry build run side by side from one clock and reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } timing_t;

  typedef struct packed {
    timing_t big;
    timing_t nod;
    timing_t sml;
  } exp_t;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  logic [9:0]  b_x, b_y, n_x, n_y, s_x, s_y;
  logic        b_blank, b_hs, b_vs, b_ls, b_fs;
  logic        n_blank, n_hs, n_vs, n_ls, n_fs;
  logic        s_blank, s_hs, s_vs, s_ls, s_fs;
  logic [15:0] b_fc, n_fc, s_fc;

  timing_t obs_big, obs_nod, obs_sml;
  assign obs_big = {b_x, b_y, b_blank, b_hs, b_vs, b_ls, b_fs, b_fc};
  assign obs_nod = {n_x, n_y, n_blank, n_hs, n_vs, n_ls, n_fs, n_fc};
  assign obs_sml = {s_x, s_y, s_blank, s_hs, s_vs, s_ls, s_fs, s_fc};

  vga_timing_gen dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
    .hs(b_hs), .vs(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(.SYNC_DELAY(0)) dut_nodly (
    .vga_clk(vga_clk), .reset(reset), .DrawX(n_x), .DrawY(n_y), .blank(n_blank),
    .hs(n_hs), .vs(n_vs), .line_start(n_ls), .frame_start(n_fs), .frame_count(n_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4), .SYNC_DELAY(2)
  ) dut_small (
    .vga_clk(vga_clk), .reset(reset), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  always #20 vga_clk = ~vga_clk;

  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  int   bx, by, bfc, sx, sy, sfc;
  exp_t exp_q[$];

  // Expected outputs from a raster position; sync looks back 'd' pixels in linear time.
  function automatic timing_t calc(input int x, input int y, input int fc,
                                   input int hv, input int hf, input int hsw, input int ht,
                                   input int vv, input int vf, input int vsw, input int vt,
                                   input int d);
    timing_t r;
    int ft, q, hq, vq;
    ft = ht * vt;
    q  = (y * ht + x - d + ft) % ft;
    hq = q % ht;
    vq = q / ht;
    r.x     = 10'(x);
    r.y     = 10'(y);
    r.blank = (x < hv) && (y < vv);
    r.hs    = !((hq >= hv + hf) && (hq < hv + hf + hsw));
    r.vs    = !((vq >= vv + vf) && (vq < vv + vf + vsw));
    r.ls    = (x == 0);
    r.fs    = (x == 0) && (y == 0);
    r.fc    = 16'(fc);
    return r;
  endfunction

  task automatic model_reset();
    bx = 799; by = 524; bfc = 0;
    sx = 31;  sy = 19;  sfc = 0;
  endtask

  task automatic model_advance();
    if (bx == 799) begin bx = 0; by = (by == 524) ? 0 : by + 1; end else bx++;
    if (bx == 0 && by == 0) bfc = (bfc + 1) % 65536;
    if (sx == 31) begin sx = 0; sy = (sy == 19) ? 0 : sy + 1; end else sx++;
    if (sx == 0 && sy == 0) sfc = (sfc + 1) % 65536;
  endtask

  task automatic push_expected();
    exp_t e;
    e.big = calc(bx, by, bfc, 640, 16, 96, 800, 480, 10, 2, 525, 2);
    e.nod = calc(bx, by, bfc, 640, 16, 96, 800, 480, 10, 2, 525, 0);
    e.sml = calc(sx, sy, sfc, 16, 4, 6, 32, 12, 2, 2, 20, 2);
    exp_q.push_back(e);
  endtask

  // One clock: advance the model at the edge, queue its prediction, return at the falling edge.
  task automatic step();
    @(posedge vga_clk);
    if (reset) model_reset(); else model_advance();
    push_expected();
    cyc++;
    @(negedge vga_clk);
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs_big !== e.big) $display("[TB] FAIL reset_hold_big cyc=%0d got=%h exp=%h", cyc, obs_big, e.big);
      else passes++;
      checks++;
      if (obs_sml !== e.sml) $display("[TB] FAIL reset_hold_small cyc=%0d got=%h exp=%h", cyc, obs_sml, e.sml);
      else passes++;
    end
    checks++;
    if ({b_x, b_y, b_blank, b_hs, b_vs, b_ls, b_fs, b_fc} !==
        {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0})
      $display("[TB] FAIL reset_values got=%0d,%0d,%b%b%b%b%b,%0d exp=799,524,01100,0",
               b_x, b_y, b_blank, b_hs, b_vs, b_ls, b_fs, b_fc);
    else passes++;
    reset = 1'b0;
    step();
    e = exp_q.pop_front();
    checks++;
    if (obs_big !== e.big) $display("[TB] FAIL first_edge_big got=%h exp=%h", obs_big, e.big);
    else passes++;
    checks++;
    if (obs_nod !== e.nod) $display("[TB] FAIL first_edge_nodly got=%h exp=%h", obs_nod, e.nod);
    else passes++;
    checks++;
    if ({b_x, b_y, b_blank, b_ls, b_fs, b_fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 16'd1})
      $display("[TB] FAIL first_edge_values got=%0d,%0d,%b%b%b,%0d exp=0,0,111,1",
               b_x, b_y, b_blank, b_ls, b_fs, b_fc);
    else passes++;
  endtask

  task automatic test_one_line();
    exp_t e;
    int blank_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
    int hs0_cnt = 0, hs0_first = -1, hs0_last = -1;
    for (int i = 0; i < 800; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs_big !== e.big) $display("[TB] FAIL line_big cyc=%0d got=%h exp=%h", cyc, obs_big, e.big);
      else passes++;
      checks++;
      if (obs_nod !== e.nod) $display("[TB] FAIL line_nodly cyc=%0d got=%h exp=%h", cyc, obs_nod, e.nod);
      else passes++;
      if (b_blank) blank_cnt++;
      if (!b_hs) begin hs_cnt++; if (hs_first < 0) hs_first = int'(b_x); hs_last = int'(b_x); end
      if (!n_hs) begin hs0_cnt++; if (hs0_first < 0) hs0_first = int'(n_x); hs0_last = int'(n_x); end
    end
    checks++;
    if (blank_cnt != 640) $display("[TB] FAIL line_blank_count got=%0d exp=640", blank_cnt);
    else passes++;
    checks++;
    if (hs_first != 658 || hs_last != 753 || hs_cnt != 96)
      $display("[TB] FAIL line_hs_window got=%0d..%0d n=%0d exp=658..753 n=96", hs_first, hs_last, hs_cnt);
    else passes++;
    checks++;
    if (hs0_first != 656 || hs0_last != 751 || hs0_cnt != 96)
      $display("[TB] FAIL line_hs_nodly_window got=%0d..%0d n=%0d exp=656..751 n=96", hs0_first, hs0_last, hs0_cnt);
    else passes++;
  endtask

  task automatic test_line_wrap();
    exp_t e;
    for (int i = 0; i < 799; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs_big !== e.big) $display("[TB] FAIL wrap_run_big cyc=%0d got=%h exp=%h", cyc, obs_big, e.big);
      else passes++;
    end
    checks++;
    if (b_x !== 10'd799 || b_y !== 10'd1) $display("[TB] FAIL wrap_pre got=%0d,%0d exp=799,1", b_x, b_y);
    else passes++;
    step();
    e = exp_q.pop_front();
    checks++;
    if ({b_x, b_y, b_ls, b_fs} !== {10'd0, 10'd2, 1'b1, 1'b0})
      $display("[TB] FAIL wrap_edge got=%0d,%0d ls=%b fs=%b exp=0,2 ls=1 fs=0", b_x, b_y, b_ls, b_fs);
    else passes++;
    step();
    e = exp_q.pop_front();
    checks++;
    if ({b_x, b_y, b_ls} !== {10'd1, 10'd2, 1'b0})
      $display("[TB] FAIL wrap_after got=%0d,%0d ls=%b exp=1,2 ls=0", b_x, b_y, b_ls);
    else passes++;
  endtask

  task automatic test_small_frame();
    exp_t e;
    int pulses = 0, last = 0, period = -1, bl = 0, vl = 0, frame_bl = -1, frame_vl = -1;
    int vs_fx = -1, vs_fy = -1, vs_lx = -1, vs_ly = -1;
    logic [15:0] fc1 = '0, fc2 = '0;
    for (int i = 0; i < 2000 && pulses < 2; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs_sml !== e.sml) $display("[TB] FAIL frame_small cyc=%0d got=%h exp=%h", cyc, obs_sml, e.sml);
      else passes++;
      if (s_fs) begin
        if (pulses == 1) begin period = cyc - last; frame_bl = bl; frame_vl = vl; fc2 = s_fc; end
        else fc1 = s_fc;
        pulses++; last = cyc; bl = 0; vl = 0;
      end
      if (s_blank) bl++;
      if (!s_vs) begin
        vl++;
        if (pulses == 1 && vs_fx < 0) begin vs_fx = int'(s_x); vs_fy = int'(s_y); end
        if (pulses == 1) begin vs_lx = int'(s_x); vs_ly = int'(s_y); end
      end
    end
    checks++;
    if (pulses != 2) $display("[TB] FAIL frame_timeout pulses=%0d exp=2", pulses);
    else passes++;
    checks++;
    if (period != 640) $display("[TB] FAIL frame_period got=%0d exp=640", period);
    else passes++;
    checks++;
    if (frame_bl != 192) $display("[TB] FAIL frame_blank_count got=%0d exp=192", frame_bl);
    else passes++;
    checks++;
    if (frame_vl != 64 || vs_fx != 2 || vs_fy != 14 || vs_lx != 1 || vs_ly != 16)
      $display("[TB] FAIL frame_vs_window got=(%0d,%0d)..(%0d,%0d) n=%0d exp=(2,14)..(1,16) n=64",
               vs_fx, vs_fy, vs_lx, vs_ly, frame_vl);
    else passes++;
    checks++;
    if (fc2 !== fc1 + 16'd1) $display("[TB] FAIL frame_count_step got=%0d exp=%0d", fc2, fc1 + 16'd1);
    else passes++;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    for (int i = 0; i < 1000 && bx != 300; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs_big !== e.big) $display("[TB] FAIL mid_run_big cyc=%0d got=%h exp=%h", cyc, obs_big, e.big);
      else passes++;
    end
    checks++;
    if (bx != 300) $display("[TB] FAIL mid_reach_timeout got=%0d exp=300", bx);
    else passes++;
    reset = 1'b1;
    #1;
    model_reset();
    push_expected();
    e = exp_q.pop_front();
    checks++;
    if ({b_x, b_y, b_blank, b_hs, b_vs, b_ls, b_fs, b_fc} !==
        {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0})
      $display("[TB] FAIL mid_async_values got=%0d,%0d,%b%b%b%b%b,%0d exp=799,524,01100,0",
               b_x, b_y, b_blank, b_hs, b_vs, b_ls, b_fs, b_fc);
    else passes++;
    checks++;
    if (obs_sml !== e.sml || obs_nod !== e.nod)
      $display("[TB] FAIL mid_async_others got=%h/%h exp=%h/%h", obs_nod, obs_sml, e.nod, e.sml);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs_big !== e.big) $display("[TB] FAIL mid_hold_big cyc=%0d got=%h exp=%h", cyc, obs_big, e.big);
      else passes++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs_big !== e.big) $display("[TB] FAIL mid_restart_big cyc=%0d got=%h exp=%h", cyc, obs_big, e.big);
      else passes++;
      if (i == 0) begin
        checks++;
        if ({b_x, b_y, b_fs, b_hs, b_fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 16'd1})
          $display("[TB] FAIL mid_restart_values got=%0d,%0d fs=%b hs=%b fc=%0d exp=0,0 fs=1 hs=1 fc=1",
                   b_x, b_y, b_fs, b_hs, b_fc);
        else passes++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_one_line();
    test_line_wrap();
    test_small_frame();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
